// File: rtl/reset_seq_ctrl.sv
// Power-up / soft-reset sequencer: holds every stage in reset, then releases the stages
// one at a time in index order, waiting for each acknowledge and allowing a settling gap.
module reset_seq_ctrl #(
    parameter int unsigned NUM_STAGES     = 4,
    parameter int unsigned HOLD_CYCLES    = 800,
    parameter int unsigned GAP_CYCLES     = 16,
    parameter int unsigned TIMEOUT_CYCLES = 65535,
    parameter int unsigned CNT_W          = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  soft_rst_req,
    input  logic [NUM_STAGES-1:0] stage_ack,
    input  logic [NUM_STAGES-1:0] ack_mask,
    output logic [NUM_STAGES-1:0] stage_rst,
    output logic                  seq_done,
    output logic                  seq_fault,
    output logic [2:0]            fault_stage,
    output logic                  busy
);

    typedef enum logic [2:0] {
        S_HOLD,
        S_RELEASE,
        S_WAIT_ACK,
        S_GAP,
        S_DONE,
        S_FAULT
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0]       LAST_IDX     = 3'(NUM_STAGES - 1);

    state_t                  state;
    logic [CNT_W-1:0]        cnt;
    logic [2:0]              idx;
    logic [NUM_STAGES-1:0]   ack_meta;
    logic [NUM_STAGES-1:0]   ack_sync;

    logic                    ack_ok;
    logic [NUM_STAGES-1:0]   release_mask;
    logic [NUM_STAGES-1:0]   lost;
    logic                    lost_any;
    logic [2:0]              lost_idx;

    // Reset pattern after a fault: the faulting stage and everything above it go back into reset.
    function automatic logic [NUM_STAGES-1:0] upper_mask(input logic [2:0] from);
        logic [NUM_STAGES-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < NUM_STAGES; i++) begin
            m[i] = (3'(i) >= from);
        end
        return m;
    endfunction

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ack_meta <= '0;
            ack_sync <= '0;
        end else begin
            ack_meta <= stage_ack;
            ack_sync <= ack_meta;
        end
    end

    // Decoded views of idx and the lost-acknowledge vector; avoids out-of-range selects
    // when NUM_STAGES is not a power of two.
    always_comb begin
        ack_ok       = 1'b0;
        release_mask = '0;
        for (int unsigned i = 0; i < NUM_STAGES; i++) begin
            if (3'(i) == idx) begin
                ack_ok          = ack_mask[i] | ack_sync[i];
                release_mask[i] = 1'b1;
            end
        end
    end

    assign lost     = ~ack_mask & ~ack_sync;
    assign lost_any = |lost;

    always_comb begin
        lost_idx = '0;
        for (int unsigned i = NUM_STAGES; i > 0; i--) begin
            if (lost[i-1]) begin
                lost_idx = 3'(i - 1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= S_HOLD;
            cnt         <= '0;
            idx         <= '0;
            stage_rst   <= '1;
            seq_done    <= 1'b0;
            seq_fault   <= 1'b0;
            fault_stage <= '0;
            busy        <= 1'b1;
        end else if (soft_rst_req) begin
            state       <= S_HOLD;
            cnt         <= '0;
            idx         <= '0;
            stage_rst   <= '1;
            seq_done    <= 1'b0;
            seq_fault   <= 1'b0;
            fault_stage <= '0;
            busy        <= 1'b1;
        end else begin
            case (state)
                S_HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        state <= S_RELEASE;
                        cnt   <= '0;
                        idx   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                S_RELEASE: begin
                    stage_rst <= stage_rst & ~release_mask;
                    state     <= S_WAIT_ACK;
                    cnt       <= '0;
                end

                S_WAIT_ACK: begin
                    if (ack_ok) begin
                        state <= S_GAP;
                        cnt   <= '0;
                    end else if (cnt == TIMEOUT_LAST) begin
                        state       <= S_FAULT;
                        seq_fault   <= 1'b1;
                        seq_done    <= 1'b0;
                        busy        <= 1'b0;
                        fault_stage <= idx;
                        stage_rst   <= upper_mask(idx);
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                S_GAP: begin
                    if (cnt == GAP_LAST) begin
                        cnt <= '0;
                        if (idx == LAST_IDX) begin
                            state    <= S_DONE;
                            seq_done <= 1'b1;
                            busy     <= 1'b0;
                        end else begin
                            idx   <= idx + 3'd1;
                            state <= S_RELEASE;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                S_DONE: begin
                    if (lost_any) begin
                        state       <= S_FAULT;
                        seq_fault   <= 1'b1;
                        seq_done    <= 1'b0;
                        busy        <= 1'b0;
                        fault_stage <= lost_idx;
                        stage_rst   <= upper_mask(lost_idx);
                    end
                end

                S_FAULT: begin
                    state <= S_FAULT;
                end

                default: begin
                    state     <= S_HOLD;
                    cnt       <= '0;
                    idx       <= '0;
                    stage_rst <= '1;
                    busy      <= 1'b1;
                end
            endcase
        end
    end

endmodule
